// File: rtl/nes_mem_scheduler_if.sv
// Requester and SDRAM-side bus bundle for nes_mem_scheduler.
// master: loader/host requesters plus SDRAM model; slave: the scheduler.
interface nes_mem_scheduler_if #(
    parameter int ADDR_W = 22
);
    logic              ldr_valid;
    logic [ADDR_W-1:0] ldr_addr;
    logic [7:0]        ldr_data;
    logic              ldr_ready;

    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic              host_ack;
    logic [7:0]        host_data;

    logic [ADDR_W+2:0] sd_addr;
    logic              sd_we;
    logic [7:0]        sd_din;
    logic              sd_oeA;
    logic              sd_oeB;
    logic [7:0]        sd_doutA;

    modport master (
        output ldr_valid, ldr_addr, ldr_data,
        input  ldr_ready,
        output host_req, host_addr,
        input  host_ack, host_data,
        input  sd_addr, sd_we, sd_din, sd_oeA, sd_oeB,
        output sd_doutA
    );

    modport slave (
        input  ldr_valid, ldr_addr, ldr_data,
        output ldr_ready,
        input  host_req, host_addr,
        output host_ack, host_data,
        output sd_addr, sd_we, sd_din, sd_oeA, sd_oeB,
        input  sd_doutA
    );
endinterface

// File: rtl/nes_mem_scheduler.sv
// Slot scheduler for the shared SDRAM port: loader FIFO, NES, host reads.
// Ports: clock/R_reset, nes_ce slot phase, load_done, NES strobes,
// nes_hold, fifo_level, and the bus interface (loader/host/sdram).
module nes_mem_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 22
) (
    input  logic                         clock,
    input  logic                         R_reset,
    input  logic [1:0]                   nes_ce,
    input  logic                         load_done,
    input  logic [ADDR_W-1:0]            nes_addr,
    input  logic                         nes_rd_cpu,
    input  logic                         nes_rd_ppu,
    input  logic                         nes_wr,
    input  logic [7:0]                   nes_dout,
    output logic                         nes_hold,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    nes_mem_scheduler_if.slave           bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        LOAD_IDLE,
        LOAD_WR,
        NES,
        HOST
    } sel_t;

    sel_t              sel_q, sel_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              host_ack_q, host_ack_d;
    logic [7:0]        host_data_q, host_data_d;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];

    logic boundary;
    logic in_load;
    logic fifo_empty;
    logic push;
    logic pop;

    assign boundary   = (nes_ce == 2'd3);
    assign in_load    = (sel_q == LOAD_IDLE) || (sel_q == LOAD_WR);
    assign fifo_empty = (level_q == '0);

    assign bus.ldr_ready = (level_q < LVL_W'(FIFO_DEPTH)) & ~R_reset;
    assign push          = bus.ldr_valid & bus.ldr_ready;

    // Owner decision, evaluated only on the boundary edge.
    // Leaving HOST always goes somewhere other than HOST, which gives the
    // one-idle-slot spacing between host reads for free.
    always_comb begin
        sel_d       = sel_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        host_ack_d  = 1'b0;
        host_data_d = host_data_q;
        pop         = 1'b0;
        if (boundary) begin
            if (sel_q == HOST) begin
                host_ack_d  = 1'b1;
                host_data_d = bus.sd_doutA;
            end
            if (!load_done || in_load) begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    sel_d      = LOAD_WR;
                    cmd_addr_d = fifo_addr[rd_ptr_q];
                    cmd_data_d = fifo_data[rd_ptr_q];
                end else if (load_done) begin
                    sel_d = NES;
                end else begin
                    sel_d = LOAD_IDLE;
                end
            end else if (sel_q == NES && bus.host_req) begin
                sel_d      = HOST;
                cmd_addr_d = bus.host_addr;
            end else begin
                sel_d = NES;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (R_reset) begin
            sel_q       <= LOAD_IDLE;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            host_ack_q  <= 1'b0;
            host_data_q <= '0;
        end else begin
            sel_q       <= sel_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            host_ack_q  <= host_ack_d;
            host_data_q <= host_data_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= bus.ldr_addr;
            fifo_data[wr_ptr_q] <= bus.ldr_data;
        end
    end

    always_comb begin
        bus.sd_addr = {3'b000, cmd_addr_q};
        bus.sd_we   = 1'b0;
        bus.sd_din  = cmd_data_q;
        bus.sd_oeA  = 1'b0;
        bus.sd_oeB  = 1'b0;
        unique case (sel_q)
            LOAD_IDLE: ;
            LOAD_WR: bus.sd_we = 1'b1;
            NES: begin
                bus.sd_addr = {3'b000, nes_addr};
                bus.sd_we   = nes_wr;
                bus.sd_din  = nes_dout;
                bus.sd_oeA  = nes_rd_cpu;
                bus.sd_oeB  = nes_rd_ppu;
            end
            HOST: begin
                bus.sd_din = 8'h00;
                bus.sd_oeA = 1'b1;
            end
        endcase
    end

    assign nes_hold      = (sel_q != NES);
    assign fifo_level    = level_q;
    assign bus.host_ack  = host_ack_q;
    assign bus.host_data = host_data_q;
endmodule

// File: tb/tb_nes_mem_scheduler.sv
// Randomized bench for nes_mem_scheduler against a queue-based slot model.
// Drives loader, NES, host and SDRAM read data; checks every cycle.
module tb_nes_mem_scheduler;
    localparam int D  = 4;
    localparam int AW = 22;

    localparam int O_IDLE = 0;
    localparam int O_WR   = 1;
    localparam int O_NES  = 2;
    localparam int O_HOST = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              R_reset;
    logic [1:0]        nes_ce;
    logic              load_done;
    logic [AW-1:0]     nes_addr;
    logic              nes_rd_cpu;
    logic              nes_rd_ppu;
    logic              nes_wr;
    logic [7:0]        nes_dout;
    logic              nes_hold;
    logic [$clog2(D):0] fifo_level;

    nes_mem_scheduler_if #(.ADDR_W(AW)) bus ();

    nes_mem_scheduler #(.FIFO_DEPTH(D), .ADDR_W(AW)) dut (
        .clock      (clock),
        .R_reset    (R_reset),
        .nes_ce     (nes_ce),
        .load_done  (load_done),
        .nes_addr   (nes_addr),
        .nes_rd_cpu (nes_rd_cpu),
        .nes_rd_ppu (nes_rd_ppu),
        .nes_wr     (nes_wr),
        .nes_dout   (nes_dout),
        .nes_hold   (nes_hold),
        .fifo_level (fifo_level),
        .bus        (bus)
    );

    // Read-only SDRAM contents.
    function automatic logic [7:0] memf(input logic [AW+2:0] a);
        if (a == 25'h001234) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ {5'b0, a[24:22]} ^ 8'hC3;
    endfunction

    always_comb bus.sd_doutA = memf(bus.sd_addr);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;

    ent_t          mq[$];
    int            m_own;
    logic [AW-1:0] m_caddr;
    logic [7:0]    m_cdata;
    logic          m_ack;
    logic [7:0]    m_hdata;
    int            wr_slots;

    // Advance the slot model by one clock, using the inputs seen at the edge.
    task automatic model_edge();
        bit   do_push;
        ent_t e;
        ent_t h;
        if (R_reset) begin
            mq.delete();
            m_own   = O_IDLE;
            m_caddr = '0;
            m_cdata = '0;
            m_ack   = 1'b0;
            m_hdata = '0;
            return;
        end
        do_push = bus.ldr_valid && (mq.size() < D);
        e       = '{a: bus.ldr_addr, d: bus.ldr_data};
        m_ack   = 1'b0;
        if (nes_ce == 2'd3) begin
            if (m_own == O_HOST) begin
                m_ack   = 1'b1;
                m_hdata = memf({3'b000, m_caddr});
            end
            if (!load_done || m_own == O_IDLE || m_own == O_WR) begin
                if (mq.size() > 0) begin
                    h       = mq.pop_front();
                    m_own   = O_WR;
                    m_caddr = h.a;
                    m_cdata = h.d;
                    wr_slots++;
                end else begin
                    m_own = load_done ? O_NES : O_IDLE;
                end
            end else if (m_own == O_NES && bus.host_req) begin
                m_own   = O_HOST;
                m_caddr = bus.host_addr;
            end else begin
                m_own = O_NES;
            end
        end
        if (do_push) mq.push_back(e);
    endtask

    task automatic chk_comb();
        logic [AW+2:0] ea;
        logic          ewe;
        logic [7:0]    ed;
        logic          eoa;
        logic          eob;
        ea  = {3'b000, m_caddr};
        ewe = 1'b0;
        ed  = m_cdata;
        eoa = 1'b0;
        eob = 1'b0;
        case (m_own)
            O_WR: ewe = 1'b1;
            O_NES: begin
                ea  = {3'b000, nes_addr};
                ewe = nes_wr;
                ed  = nes_dout;
                eoa = nes_rd_cpu;
                eob = nes_rd_ppu;
            end
            O_HOST: begin
                ed  = 8'h00;
                eoa = 1'b1;
            end
            default: ;
        endcase
        chk("ldr_ready", 32'(bus.ldr_ready),
            32'((mq.size() < D) && !R_reset));
        chk("sd_addr", 32'(bus.sd_addr), 32'(ea));
        chk("sd_we",   32'(bus.sd_we),   32'(ewe));
        chk("sd_din",  32'(bus.sd_din),  32'(ed));
        chk("sd_oeA",  32'(bus.sd_oeA),  32'(eoa));
        chk("sd_oeB",  32'(bus.sd_oeB),  32'(eob));
    endtask

    // One clock: check outputs for the current inputs, clock the model,
    // check registered outputs, advance the phase.
    task automatic cyc();
        #1;
        chk_comb();
        @(posedge clock);
        model_edge();
        #1;
        chk("host_ack",   32'(bus.host_ack),  32'(m_ack));
        chk("host_data",  32'(bus.host_data), 32'(m_hdata));
        chk("nes_hold",   32'(nes_hold),      32'(m_own != O_NES));
        chk("fifo_level", 32'(fifo_level),    32'(mq.size()));
        nes_ce = nes_ce + 2'd1;
        if (m_ack) bus.host_req = 1'b0;
    endtask

    task automatic rnd_nes();
        nes_addr   = AW'($urandom);
        nes_rd_cpu = 1'($urandom);
        nes_rd_ppu = 1'($urandom);
        nes_wr     = 1'($urandom);
        nes_dout   = 8'($urandom);
    endtask

    task automatic rnd_ldr(input int pct);
        bus.ldr_valid = ($urandom_range(0, 99) < pct);
        bus.ldr_addr  = ($urandom_range(0, 7) == 0) ? 22'h3FFFFF
                                                    : AW'($urandom);
        bus.ldr_data  = 8'($urandom);
    endtask

    task automatic rnd_host(input int pct);
        if (!bus.host_req && $urandom_range(0, 99) < pct) begin
            bus.host_req  = 1'b1;
            bus.host_addr = ($urandom_range(0, 3) == 0) ? 22'h001234
                                                        : AW'($urandom);
        end
    endtask

    task automatic push1(input logic [AW-1:0] a, input logic [7:0] d);
        bus.ldr_valid = 1'b1;
        bus.ldr_addr  = a;
        bus.ldr_data  = d;
        cyc();
        bus.ldr_valid = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;
        R_reset       = 1'b1;
        nes_ce        = 2'd0;
        load_done     = 1'b0;
        bus.ldr_valid = 1'b0;
        bus.ldr_addr  = '0;
        bus.ldr_data  = '0;
        bus.host_req  = 1'b0;
        bus.host_addr = '0;
        wr_slots      = 0;
        m_own         = O_IDLE;
        m_caddr       = '0;
        m_cdata       = '0;
        m_ack         = 1'b0;
        m_hdata       = '0;
        rnd_nes();
        repeat (3) cyc();
        R_reset = 1'b0;

        // Loader drain, three back-to-back pushes.
        push1(22'h000010, 8'hA5);
        push1(22'h000011, 8'h5A);
        push1(22'h3FFFFF, 8'hFF);
        repeat (20) begin rnd_nes(); cyc(); end
        chk("drain_slots", 32'(wr_slots), 32'd3);

        // FIFO full: six valid cycles, then a handover while data remains.
        bus.ldr_valid = 1'b1;
        repeat (6) begin rnd_ldr(100); cyc(); end
        bus.ldr_valid = 1'b0;
        load_done = 1'b1;
        repeat (30) begin rnd_nes(); cyc(); end
        chk("in_run", 32'(nes_hold), 32'd0);

        // Directed host read of 0x001234.
        bus.host_req  = 1'b1;
        bus.host_addr = 22'h001234;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            rnd_nes();
            cyc();
            if (m_ack) begin
                seen = 1'b1;
                chk("host_3c", 32'(bus.host_data), 32'h3C);
            end
            n++;
        end
        chk("host_ack_seen", 32'(seen), 32'd1);

        // Random RUN traffic.
        repeat (400) begin
            rnd_nes(); rnd_ldr(5); rnd_host(30); cyc();
        end
        bus.ldr_valid = 1'b0;

        // Reload with a host request raised at the same moment.
        load_done = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_addr = AW'($urandom);
        repeat (30) begin rnd_nes(); rnd_ldr(20); cyc(); end
        bus.ldr_valid = 1'b0;
        load_done = 1'b1;
        repeat (30) begin rnd_nes(); cyc(); end

        // Reset while a host slot is in flight, with FIFO entries queued.
        push1(AW'($urandom), 8'h11);
        push1(AW'($urandom), 8'h22);
        rnd_host(100);
        n = 0;
        while (m_own != O_HOST && n < 40) begin rnd_nes(); cyc(); n++; end
        chk("host_slot_reached", 32'(m_own), 32'(O_HOST));
        R_reset = 1'b1;
        cyc();
        R_reset = 1'b0;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_hold",  32'(nes_hold),   32'd1);
        repeat (20) begin rnd_nes(); cyc(); end

        // Full random mix.
        repeat (2500) begin
            rnd_nes();
            rnd_ldr(load_done ? 5 : 40);
            rnd_host(25);
            if ($urandom_range(0, 199) == 0) load_done = ~load_done;
            R_reset = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
